// File: rtl/pixel_gen.sv
// Per-pixel RGB generator for a VGA timing block: bouncing box, colour bars, or checkerboard
// with the box overlaid. The box moves once per frame; a push button steps through the modes.
module pixel_gen #(
  parameter int BOX     = 32,
  parameter int STEP    = 2,
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int H_ACT   = 640,
  parameter int V_ACT   = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       btn_mode,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic       frame_tick,
  output logic [1:0] mode
);

  localparam logic [1:0] MODE_BOX   = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;

  localparam logic [9:0]  X_LO   = 10'(H_START);
  localparam logic [9:0]  X_HI   = 10'(H_START + H_ACT);
  localparam logic [9:0]  Y_LO   = 10'(V_START);
  localparam logic [9:0]  Y_HI   = 10'(V_START + V_ACT);
  localparam logic [10:0] BOX_W  = 11'(BOX);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_LIM  = 11'(H_ACT);
  localparam logic [10:0] Y_LIM  = 11'(V_ACT);
  localparam logic [9:0]  X_INIT = 10'((H_ACT - BOX) / 2);
  localparam logic [9:0]  Y_INIT = 10'((V_ACT - BOX) / 2);

  logic [9:0] box_x, box_y;
  logic       dir_x, dir_y;
  logic       s1, s2, s2_d;
  logic       btn_edge;
  logic       frame_start;
  logic       active;
  logic       in_box;
  logic [9:0] ax, ay;
  logic [2:0] bar;
  logic [2:0] rgb_n;

  // Returns {new_dir, new_pos}; the position clamps to the wall and the direction flips there.
  function automatic logic [10:0] bounce(input logic [9:0] pos, input logic dir,
                                         input logic [10:0] lim);
    logic [10:0] p;
    logic [9:0]  top;
    p   = {1'b0, pos};
    top = 10'(lim - BOX_W);
    if (dir) begin
      if (p + BOX_W + STEP_W > lim) begin
        bounce = {1'b0, top};
      end else begin
        p      = p + STEP_W;
        bounce = {1'b1, p[9:0]};
      end
    end else begin
      if (p < STEP_W) begin
        bounce = {1'b1, 10'd0};
      end else begin
        p      = p - STEP_W;
        bounce = {1'b0, p[9:0]};
      end
    end
  endfunction

  assign frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign ax          = pixel_x - X_LO;
  assign ay          = pixel_y - Y_LO;
  assign active      = (pixel_x >= X_LO) && (pixel_x < X_HI) &&
                       (pixel_y >= Y_LO) && (pixel_y < Y_HI);
  assign in_box      = ({1'b0, ax} >= {1'b0, box_x}) && ({1'b0, ax} < {1'b0, box_x} + BOX_W) &&
                       ({1'b0, ay} >= {1'b0, box_y}) && ({1'b0, ay} < {1'b0, box_y} + BOX_W);
  assign btn_edge    = s2 & ~s2_d;

  // Bar index from a comparator chain on 80-pixel boundaries.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (ax >= 10'(80 * i)) bar = 3'(i);
    end
  end

  always_comb begin
    rgb_n = 3'b000;
    if (active) begin
      case (mode)
        MODE_BOX:   rgb_n = in_box ? 3'b111 : 3'b001;
        MODE_BARS:  rgb_n = bar;
        MODE_CHECK: rgb_n = in_box ? 3'b100 : ((ax[5] ^ ay[5]) ? 3'b111 : 3'b000);
        default:    rgb_n = 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red   <= 1'b0;
      green <= 1'b0;
      blue  <= 1'b0;
    end else begin
      {red, green, blue} <= rgb_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      box_x      <= X_INIT;
      box_y      <= Y_INIT;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_start;
      if (frame_start) begin
        {dir_x, box_x} <= bounce(box_x, dir_x, X_LIM);
        {dir_y, box_y} <= bounce(box_y, dir_y, Y_LIM);
      end
    end
  end

  // A button held through reset release looks like a fresh press because s2_d restarts at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
      mode <= MODE_BOX;
    end else begin
      s1   <= btn_mode;
      s2   <= s1;
      s2_d <= s2;
      if (btn_edge) mode <= (mode == MODE_CHECK) ? MODE_BOX : mode + 2'd1;
    end
  end

endmodule

// File: tb/tb_pixel_gen.sv
// Bench for pixel_gen: random pixels and frame updates checked against a behavioural model.
module tb_pixel_gen;
  localparam int BOX     = 32;
  localparam int STEP    = 2;
  localparam int H_START = 144;
  localparam int V_START = 35;
  localparam int H_ACT   = 640;
  localparam int V_ACT   = 480;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixel_x, pixel_y;
  logic       btn_mode;
  logic       red, green, blue, frame_tick;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_bad = 0;

  int m_bx, m_by, m_mode;
  bit m_dx, m_dy;
  logic [2:0] exp_q[$];

  pixel_gen dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y), .btn_mode(btn_mode),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_bx = (H_ACT - BOX) / 2;
    m_by = (V_ACT - BOX) / 2;
    m_dx = 1'b1;
    m_dy = 1'b1;
    m_mode = 0;
  endfunction

  // Box moves by +/-STEP, stays inside [0, ACT-BOX], and reverses whenever it gets clamped.
  function automatic void model_frame();
    int nx, ny;
    nx = m_bx + (m_dx ? STEP : -STEP);
    ny = m_by + (m_dy ? STEP : -STEP);
    if (nx > H_ACT - BOX) begin nx = H_ACT - BOX; m_dx = !m_dx; end
    else if (nx < 0) begin nx = 0; m_dx = !m_dx; end
    if (ny > V_ACT - BOX) begin ny = V_ACT - BOX; m_dy = !m_dy; end
    else if (ny < 0) begin ny = 0; m_dy = !m_dy; end
    m_bx = nx;
    m_by = ny;
  endfunction

  function automatic logic [2:0] exp_rgb(int x, int y);
    int ax, ay;
    bit inb;
    ax = x - H_START;
    ay = y - V_START;
    if (ax < 0 || ax >= H_ACT || ay < 0 || ay >= V_ACT) return 3'b000;
    inb = (ax >= m_bx) && (ax < m_bx + BOX) && (ay >= m_by) && (ay < m_by + BOX);
    case (m_mode)
      0: return inb ? 3'b111 : 3'b001;
      1: return 3'(ax / 80);
      2: return inb ? 3'b100 : ((((ax / 32) + (ay / 32)) % 2 == 1) ? 3'b111 : 3'b000);
      default: return 3'b000;
    endcase
  endfunction

  task automatic step(input int x, input int y);
    logic [2:0] e;
    bit t;
    @(negedge clk);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    exp_q.push_back(exp_rgb(x, y));
    t = (x == 0 && y == 0);
    if (t) model_frame();
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_cmp++;
    if ({red, green, blue} !== e) begin
      n_bad++;
      $display("FAIL rgb at (%0d,%0d) mode %0d: got %b expected %b", x, y, m_mode,
               {red, green, blue}, e);
    end
    n_cmp++;
    if (frame_tick !== t) begin
      n_bad++;
      $display("FAIL frame_tick at (%0d,%0d): got %b expected %b", x, y, frame_tick, t);
    end
    n_cmp++;
    if (mode !== 2'(m_mode)) begin
      n_bad++;
      $display("FAIL mode: got %0d expected %0d", mode, m_mode);
    end
    if (t) begin
      n_cmp++;
      if (dut.box_x !== 10'(m_bx) || dut.box_y !== 10'(m_by) ||
          dut.dir_x !== m_dx || dut.dir_y !== m_dy) begin
        n_bad++;
        $display("FAIL box: got x=%0d y=%0d dx=%b dy=%b expected x=%0d y=%0d dx=%b dy=%b",
                 dut.box_x, dut.box_y, dut.dir_x, dut.dir_y, m_bx, m_by, m_dx, m_dy);
      end
    end
  endtask

  task automatic step_random();
    step($urandom_range(1, 1023), $urandom_range(0, 1023));
  endtask

  task automatic step_near_box();
    step(H_START + m_bx - 1 + $urandom_range(0, BOX + 1),
         V_START + m_by - 1 + $urandom_range(0, BOX + 1));
  endtask

  task automatic check_mode(input string tag, input int want);
    n_cmp++;
    if (mode !== 2'(want)) begin
      n_bad++;
      $display("FAIL %s: mode got %0d expected %0d", tag, mode, want);
    end
  endtask

  // One press held for 'hold' cycles: mode moves exactly two edges after the first high sample.
  task automatic press(input int hold);
    int old_m, new_m;
    old_m = m_mode;
    new_m = (m_mode + 1) % 3;
    @(negedge clk);
    pixel_x = 10'd5;
    pixel_y = 10'd5;
    btn_mode = 1'b1;
    @(posedge clk); #1; check_mode("press_k", old_m);
    @(posedge clk); #1; check_mode("press_k1", old_m);
    @(posedge clk); #1; check_mode("press_k2", new_m);
    m_mode = new_m;
    repeat (hold) @(posedge clk);
    #1; check_mode("press_held", new_m);
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (5) @(posedge clk);
    #1; check_mode("press_release", new_m);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_mode = 1'b0;
    pixel_x = 10'd200;
    pixel_y = 10'd100;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({red, green, blue, frame_tick} !== 4'b0000 || mode !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got rgbt=%b mode=%0d expected 0000/0",
               {red, green, blue, frame_tick}, mode);
    end
    n_cmp++;
    if (dut.box_x !== 10'd304 || dut.box_y !== 10'd224 || dut.dir_x !== 1'b1 || dut.dir_y !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_box: got %0d,%0d dirs %b%b expected 304,224 dirs 11",
               dut.box_x, dut.box_y, dut.dir_x, dut.dir_y);
    end
    reset = 1'b1;
    step(H_START + 304, V_START + 224);
    step(143, 100);
    step(H_START + 303, V_START + 224);
    step(H_START + 335, V_START + 255);
    step(H_START + 336, V_START + 255);
  endtask

  task automatic test_right_wall();
    int guard;
    guard = 0;
    while (!(m_bx == 606 && m_dx) && guard < 400) begin
      step(0, 0);
      step_random();
      guard++;
    end
    n_cmp++;
    if (guard >= 400) begin
      n_bad++;
      $display("FAIL right_wall_reach: model never reached 606 (got %0d expected 606)", m_bx);
    end
    step(0, 0);
    n_cmp++;
    if (dut.box_x !== 10'd608 || dut.dir_x !== 1'b1) begin
      n_bad++;
      $display("FAIL right_wall_a: got %0d dir %b expected 608 dir 1", dut.box_x, dut.dir_x);
    end
    step_near_box();
    step(0, 0);
    n_cmp++;
    if (dut.box_x !== 10'd608 || dut.dir_x !== 1'b0) begin
      n_bad++;
      $display("FAIL right_wall_b: got %0d dir %b expected 608 dir 0", dut.box_x, dut.dir_x);
    end
    step_near_box();
    step(0, 0);
    n_cmp++;
    if (dut.box_x !== 10'd606 || dut.dir_x !== 1'b0) begin
      n_bad++;
      $display("FAIL right_wall_c: got %0d dir %b expected 606 dir 0", dut.box_x, dut.dir_x);
    end
  endtask

  task automatic test_bounce_random();
    for (int f = 0; f < 700; f++) begin
      step(0, 0);
      step_near_box();
      if ($urandom_range(0, 3) == 0) step_random();
    end
  endtask

  task automatic test_colour_bars();
    press(5);
    step(144, 100);
    step(224, 100);
    step(463, 100);
    step(783, 100);
    step(784, 100);
    for (int i = 0; i < 40; i++) step($urandom_range(130, 800), $urandom_range(20, 530));
  endtask

  task automatic test_checker();
    press(1000);
    step(H_START + 32, V_START + 0);
    step(H_START + 32, V_START + 32);
    step(H_START + m_bx + 1, V_START + m_by + 1);
    step(0, 0);
    for (int i = 0; i < 40; i++) begin
      step_random();
      step_near_box();
    end
  endtask

  task automatic test_mode_wrap();
    press(3);
    step(H_START + m_bx, V_START + m_by);
    step(H_START + 5, V_START + 5);
  endtask

  // Button edge lands on the same clock as the (0,0) frame update.
  task automatic test_simultaneous();
    int new_m;
    new_m = (m_mode + 1) % 3;
    @(negedge clk);
    pixel_x = 10'd5;
    pixel_y = 10'd5;
    btn_mode = 1'b1;
    @(posedge clk); #1; check_mode("simul_k", m_mode);
    @(posedge clk); #1; check_mode("simul_k1", m_mode);
    @(negedge clk);
    pixel_x = 10'd0;
    pixel_y = 10'd0;
    model_frame();
    m_mode = new_m;
    @(posedge clk); #1;
    check_mode("simul_k2", new_m);
    n_cmp++;
    if (frame_tick !== 1'b1 || dut.box_x !== 10'(m_bx) || dut.box_y !== 10'(m_by)) begin
      n_bad++;
      $display("FAIL simul_frame: got tick=%b box=%0d,%0d expected tick=1 box=%0d,%0d",
               frame_tick, dut.box_x, dut.box_y, m_bx, m_by);
    end
    @(negedge clk);
    btn_mode = 1'b0;
    step(H_START + m_bx + 2, V_START + m_by + 2);
    step_random();
  endtask

  task automatic test_reset_held_button();
    step(783, 100);
    @(negedge clk);
    btn_mode = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({red, green, blue, frame_tick} !== 4'b0000 || mode !== 2'd0 ||
        dut.box_x !== 10'd304 || dut.box_y !== 10'd224) begin
      n_bad++;
      $display("FAIL async_reset: got rgbt=%b mode=%0d box=%0d,%0d expected 0000/0/304,224",
               {red, green, blue, frame_tick}, mode, dut.box_x, dut.box_y);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1; check_mode("held_k", 0);
    @(posedge clk); #1; check_mode("held_k1", 0);
    @(posedge clk); #1; check_mode("held_k2", 1);
    m_mode = 1;
    @(negedge clk);
    btn_mode = 1'b0;
    repeat (4) @(posedge clk);
    step(H_START + 304, V_START + 224);
    step(0, 0);
  endtask

  initial begin
    test_reset();
    test_right_wall();
    test_bounce_random();
    test_colour_bars();
    test_checker();
    test_mode_wrap();
    test_simultaneous();
    test_reset_held_button();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "time limit");
  end

endmodule
